// File: rtl/clt_normal_accum.sv
// Central Limit Theorem accumulator: sums 2^LOG2_SAMPLES uniform samples and re-centres on zero.
// Optional macro CLT_VARIANCE_NORM_EN arithmetically scales the result by 2^-floor(LOG2_SAMPLES/2).
module clt_normal_accum #(
   parameter int unsigned IN_BITS      = 12,
   parameter int unsigned LOG2_SAMPLES = 4,
   localparam int unsigned OUT_W       = IN_BITS + LOG2_SAMPLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [OUT_W-1:0] Offset = {1'b1, {(OUT_W-1){1'b0}}};

   logic [OUT_W-1:0]        acc_q, acc_d;
   logic [LOG2_SAMPLES-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0]        out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;

   logic [OUT_W-1:0]        u_ext;
   logic [OUT_W-1:0]        sum;
   logic signed [OUT_W-1:0] centred;
   logic [OUT_W-1:0]        result;
   logic                    last;
   logic                    accept;
   logic                    unused_in;

   // Only the top IN_BITS of each sample are used.
   assign unused_in = ^in_data;
   assign u_ext     = {{LOG2_SAMPLES{1'b0}}, in_data[31 -: IN_BITS]};
   assign sum       = acc_q + u_ext;
   assign centred   = sum - Offset;

`ifdef CLT_VARIANCE_NORM_EN
   localparam int unsigned Shift = LOG2_SAMPLES / 2;
   assign result = centred >>> Shift;
`else
   assign result = centred;
`endif

   assign last     = (cnt_q == {LOG2_SAMPLES{1'b1}});
   // Only the completing sample is held off while an unconsumed result is pending.
   assign in_ready = !(out_valid_q && !out_ready && last);
   assign accept   = in_valid && in_ready;

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (flush) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (last) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_data_d  = result;
            out_valid_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule
